inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 100 ++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch front end: sequential PC generation, one-deep memory pipeline,
// and a 2-entry {pc, inst} buffer toward decode with redirect flush.
package inst_fetch_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

module inst_fetch #(
  parameter int ADDR_WIDTH = inst_fetch_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = inst_fetch_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_inst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] head_pc, tail_pc;
  logic [DATA_WIDTH-1:0] head_inst, tail_inst;
  logic [1:0]            count;
  logic                  pop, push, issue;
  logic [2:0]            occ;

  assign mem_addr = fetch_pc;
  assign out_pc   = head_pc;
  assign out_inst = head_inst;

  // occ is the buffer occupancy once this cycle's pop and the pending response settle;
  // issuing only when it is at most 1 guarantees the buffer can take the response.
  always_comb begin
    out_valid = (count != 2'd0) && !redirect_valid;
    pop       = out_valid && out_ready;
    push      = inflight && !redirect_valid;
    occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = !redirect_valid && (occ <= 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      head_pc     <= '0;
      head_inst   <= '0;
      tail_pc     <= '0;
      tail_inst   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_WIDTH'(4);
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc   <= inflight_pc;
            head_inst <= mem_inst;
          end else begin
            tail_pc   <= inflight_pc;
            tail_inst <= mem_inst;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc   <= tail_pc;
          head_inst <= tail_inst;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc   <= inflight_pc;
            head_inst <= mem_inst;
          end else begin
            head_pc   <= tail_pc;
            head_inst <= tail_inst;
            tail_pc   <= inflight_pc;
            tail_inst <= mem_inst;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
